// File: rtl/keypad_bcd_entry.sv
// 4x4 matrix keypad scanner with debounce; shifts accepted digit keys into a
// 2-digit BCD value and pulses load on '#' so the counter preset comes from the keypad.
module keypad_bcd_entry #(
  parameter logic [15:0] SCAN_DIV       = 16'd50000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] digit1,
  output logic [3:0] digit0,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       load
);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_t;

  localparam logic [3:0] DB_N = 4'(DEBOUNCE_SCANS);

  state_t      state_q, state_d;
  logic [15:0] div_q, div_d;
  logic [1:0]  col_idx_q, col_idx_d;
  logic [3:0]  row_lat_q, row_lat_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  digit1_q, digit1_d;
  logic [3:0]  digit0_q, digit0_d;
  logic [3:0]  key_code_q, key_code_d;
  logic        key_valid_q, key_valid_d;
  logic        load_q, load_d;

  logic        tick;
  logic [3:0]  row_act;
  logic        one_row;
  logic [3:0]  key_val;

  function automatic logic [1:0] row_of(input logic [3:0] act);
    if (act[0])      row_of = 2'd0;
    else if (act[1]) row_of = 2'd1;
    else if (act[2]) row_of = 2'd2;
    else             row_of = 2'd3;
  endfunction

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'h0: key_map = 4'd1;   4'h1: key_map = 4'd2;   4'h2: key_map = 4'd3;   4'h3: key_map = 4'd10;
      4'h4: key_map = 4'd4;   4'h5: key_map = 4'd5;   4'h6: key_map = 4'd6;   4'h7: key_map = 4'd11;
      4'h8: key_map = 4'd7;   4'h9: key_map = 4'd8;   4'hA: key_map = 4'd9;   4'hB: key_map = 4'd12;
      4'hC: key_map = 4'd14;  4'hD: key_map = 4'd0;   4'hE: key_map = 4'd15;  default: key_map = 4'd13;
    endcase
  endfunction

  always_comb begin
    tick    = (div_q == SCAN_DIV - 16'd1);
    div_d   = tick ? 16'd0 : div_q + 16'd1;
    row_act = ~row_n;
    one_row = (row_act != 4'd0) && ((row_act & (row_act - 4'd1)) == 4'd0);
  end

  // Next-state: the column stays frozen from first detection until release completes
  always_comb begin
    state_d   = state_q;
    col_idx_d = col_idx_q;
    row_lat_d = row_lat_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      SCAN: if (tick) begin
        if (one_row) begin
          row_lat_d = row_n;
          cnt_d     = 4'd1;
          state_d   = (DB_N == 4'd1) ? PRESSED : DEBOUNCE;
        end else begin
          col_idx_d = col_idx_q + 2'd1;
        end
      end
      DEBOUNCE: if (tick) begin
        if (row_n == row_lat_q) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q + 4'd1 == DB_N) state_d = PRESSED;
        end else begin
          cnt_d   = 4'd0;
          state_d = SCAN;
        end
      end
      PRESSED: begin
        cnt_d   = 4'd0;
        state_d = RELEASE;
      end
      RELEASE: if (tick) begin
        if (row_n != 4'hF) begin
          cnt_d = 4'd0;
        end else if (cnt_q + 4'd1 == DB_N) begin
          cnt_d   = 4'd0;
          state_d = SCAN;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
    endcase
  end

  // Outputs are registered on entry to PRESSED so they are visible during that cycle
  always_comb begin
    key_val     = key_map(row_of(~row_lat_d), col_idx_d);
    key_valid_d = 1'b0;
    load_d      = 1'b0;
    key_code_d  = key_code_q;
    digit1_d    = digit1_q;
    digit0_d    = digit0_q;
    if (state_d == PRESSED && state_q != PRESSED) begin
      key_valid_d = 1'b1;
      key_code_d  = key_val;
      if (key_val <= 4'd9) begin
        digit1_d = digit0_q;
        digit0_d = key_val;
      end else if (key_val == 4'd14) begin
        digit1_d = 4'd0;
        digit0_d = 4'd0;
      end else if (key_val == 4'd15) begin
        load_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= SCAN;
      div_q       <= 16'd0;
      col_idx_q   <= 2'd0;
      row_lat_q   <= 4'hF;
      cnt_q       <= 4'd0;
      digit1_q    <= 4'd0;
      digit0_q    <= 4'd0;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      load_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      col_idx_q   <= col_idx_d;
      row_lat_q   <= row_lat_d;
      cnt_q       <= cnt_d;
      digit1_q    <= digit1_d;
      digit0_q    <= digit0_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      load_q      <= load_d;
    end
  end

  assign col_n     = ~(4'd1 << col_idx_q);
  assign digit1    = digit1_q;
  assign digit0    = digit0_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign load      = load_q;

endmodule

// File: tb/tb_keypad_bcd_entry.sv
// Keypad bench: a switch-matrix model answers the column drive; expected digits
// come from a decimal model (value*10+key mod 100) updated per accepted press.
module tb_keypad_bcd_entry;
  localparam logic [15:0] SCAN_DIV = 16'd4;
  localparam int SD = 4;
  localparam int DS = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] row_n, col_n, digit1, digit0, key_code;
  logic       key_valid, load;
  logic [15:0] pressed;

  int key_tab [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};
  int n_tests = 0, n_fail = 0;
  int kv_cnt = 0, ld_cnt = 0;
  int exp_kv = 0, exp_ld = 0, model = 0, last_key = 0;

  keypad_bcd_entry #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DS)) dut (
    .clk(clk), .rst(rst), .row_n(row_n), .col_n(col_n), .digit1(digit1),
    .digit0(digit0), .key_valid(key_valid), .key_code(key_code), .load(load)
  );

  always #5 clk = ~clk;

  // Switch matrix: a closed key pulls its row low while its column is driven low
  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
  end

  always @(posedge clk) begin
    if (key_valid) kv_cnt <= kv_cnt + 1;
    if (load) ld_cnt <= ld_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n * SD) @(negedge clk);
  endtask

  function automatic int idx_of(input int k);
    int idx = 0;
    for (int i = 0; i < 16; i++) if (key_tab[i] == k) idx = i;
    return idx;
  endfunction

  task automatic accept(input int k);
    exp_kv++;
    last_key = k;
    if (k <= 9) model = (model * 10 + k) % 100;
    else if (k == 14) model = 0;
    else if (k == 15) exp_ld++;
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".kv"}, kv_cnt, exp_kv);
    chk({tag, ".ld"}, ld_cnt, exp_ld);
    chk({tag, ".code"}, key_code, last_key);
    chk({tag, ".d1"}, digit1, model / 10);
    chk({tag, ".d0"}, digit0, model % 10);
  endtask

  task automatic press(input int k, input int hold_t, input int gap_t);
    pressed[idx_of(k)] = 1'b1;
    ticks(hold_t);
    pressed = '0;
    ticks(gap_t);
  endtask

  // Returns on the first negedge after the scan moves onto column c
  task automatic align_col(input int c);
    logic [3:0] tgt;
    int n = 0;
    tgt = ~(4'd1 << c);
    while (col_n == tgt && n < 64) begin @(negedge clk); n++; end
    while (col_n != tgt && n < 64) begin @(negedge clk); n++; end
    chk("align", col_n, tgt);
  endtask

  initial begin
    int lat;
    pressed = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst.col", col_n, 4'b1110);
    chk("rst.d1", digit1, 0);
    chk("rst.d0", digit0, 0);
    chk("rst.code", key_code, 0);
    chk("rst.kv", key_valid, 0);
    chk("rst.ld", load, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk); chk("rot1", col_n, 4'b1101);
    repeat (4) @(negedge clk); chk("rot2", col_n, 4'b1011);
    repeat (4) @(negedge clk); chk("rot3", col_n, 4'b0111);
    repeat (4) @(negedge clk); chk("rot0", col_n, 4'b1110);

    press(5, 10, 4); accept(5); check_state("k5");
    press(7, 10, 4); accept(7); check_state("k7");

    // One-tick bounce on '5'
    align_col(1);
    pressed[idx_of(5)] = 1'b1;
    repeat (SD) @(negedge clk);
    pressed = '0;
    ticks(4);
    check_state("bounce");

    // '#' with exact latency and single-cycle load
    align_col(2);
    pressed[idx_of(15)] = 1'b1;
    lat = 0;
    while (!key_valid && lat < 64) begin @(negedge clk); lat++; end
    chk("lat", lat, DS * SD);
    chk("hash.load", load, 1);
    chk("hash.code", key_code, 15);
    @(negedge clk);
    chk("hash.kv_low", key_valid, 0);
    chk("hash.ld_low", load, 0);
    ticks(6);
    pressed = '0;
    ticks(4);
    accept(15); check_state("hash");

    press(14, 10, 4); accept(14); check_state("star");

    press(9, 50, DS); accept(9); check_state("hold9");
    press(9, 10, 4); accept(9); check_state("repress9");

    // '1' and '4' share column 0: two rows low together
    pressed[idx_of(1)] = 1'b1;
    pressed[idx_of(4)] = 1'b1;
    ticks(10);
    pressed = '0;
    ticks(4);
    check_state("multi");

    // Reset while debouncing discards the press
    align_col(1);
    pressed[idx_of(5)] = 1'b1;
    repeat (SD + 1) @(negedge clk);
    rst = 1'b1;
    pressed = '0;
    #1;
    chk("mid.col", col_n, 4'b1110);
    chk("mid.d1", digit1, 0);
    chk("mid.d0", digit0, 0);
    chk("mid.code", key_code, 0);
    model = 0;
    last_key = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    ticks(6);
    check_state("midrst");

    for (int i = 0; i < 20; i++) begin
      int k;
      k = int'($urandom_range(15));
      press(k, int'($urandom_range(14, 8)), int'($urandom_range(6, 3)));
      accept(k);
      check_state("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
